// File: rtl/mul_issue_arbiter.sv
// Issue controller for the pipelined integer multiplier.
// A round-robin picker selects one ready station per cycle. A shadow pipeline
// carries valid/tag alongside the multiplier. Results land in a small FIFO
// that drains to the CDB. Credits (in flight + buffered) never exceed DEPTH,
// so a push can never find the FIFO full.
module mul_issue_arbiter #(
  parameter int NUM_RS = 3,
  parameter int LAT    = 6,
  parameter int DEPTH  = 4
)(
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [NUM_RS-1:0]    rsReady,
  input  logic [4*NUM_RS-1:0]  rsLabel,
  input  logic [32*NUM_RS-1:0] rsData1,
  input  logic [32*NUM_RS-1:0] rsData2,
  output logic [NUM_RS-1:0]    rsGrant,
  output logic                 aluEN,
  output logic [31:0]          aluData1,
  output logic [31:0]          aluData2,
  input  logic [31:0]          aluResult,
  output logic                 cdbValid,
  output logic [31:0]          cdbData,
  output logic [3:0]           cdbLabel,
  input  logic                 cdbAck,
  output logic                 busy
);
  localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } res_t;

  logic [NUM_RS-1:0][31:0] op1, op2;
  logic [NUM_RS-1:0][3:0]  tags;

  logic [PW-1:0]          ptr, gnt_idx;
  logic                   gnt_hit, grant_ok, can_issue;
  logic [3:0]             gnt_tag;
  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][3:0]    lab_pipe;
  res_t                   mem [DEPTH];
  res_t                   head;
  logic [AW-1:0]          wp, rp;
  logic [CW-1:0]          occ, count;
  logic                   push, pop;

  assign op1  = rsData1;
  assign op2  = rsData2;
  assign tags = rsLabel;

  // Round-robin search: first ready station at ptr, ptr+1, ... (mod NUM_RS)
  always_comb begin
    logic [PW:0] cand;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_RS)) cand = cand - (PW+1)'(NUM_RS);
      if (!gnt_hit && rsReady[cand[PW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  // A credit is consumed at issue and returned only when the CDB takes the result
  assign can_issue = (count < CW'(DEPTH));
  assign grant_ok  = gnt_hit & can_issue & nRST;
  assign rsGrant   = grant_ok ? (NUM_RS'(1) << gnt_idx) : '0;
  assign aluEN     = grant_ok;
  assign aluData1  = grant_ok ? op1[gnt_idx]  : '0;
  assign aluData2  = grant_ok ? op2[gnt_idx]  : '0;
  assign gnt_tag   = grant_ok ? tags[gnt_idx] : '0;

  // Rotate priority to just past the winner
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)
      ptr <= '0;
    else if (grant_ok)
      ptr <= (gnt_idx == PW'(NUM_RS-1)) ? '0 : gnt_idx + PW'(1);
  end

  // Shadow pipeline: the multiplier's own tag output is not pipelined, so we carry tags here
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      vld_pipe <= '0;
      lab_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], aluEN};
      lab_pipe <= {lab_pipe[LAT-2:0], gnt_tag};
    end
  end

  assign push = vld_pipe[LAT-1];
  assign pop  = cdbAck & (occ != '0);

  // Result storage; contents are qualified by occupancy, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{data: aluResult, tag: lab_pipe[LAT-1]};
  end

  // FIFO pointers, occupancy and the credit counter
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wp    <= '0;
      rp    <= '0;
      occ   <= '0;
      count <= '0;
    end else begin
      if (push) wp <= (wp == AW'(DEPTH-1)) ? '0 : wp + AW'(1);
      if (pop)  rp <= (rp == AW'(DEPTH-1)) ? '0 : rp + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      // pushes only move an op from pipeline to FIFO, so they leave count alone
      case ({aluEN, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rp];
  assign cdbValid = (occ != '0);
  assign cdbData  = cdbValid ? head.data : '0;
  assign cdbLabel = cdbValid ? head.tag  : '0;
  assign busy     = (count != '0);

endmodule

// File: doc/mul_issue_arbiter.md
Name: mul_issue_arbiter

Overview:
Issue controller for the pipelined integer multiplier unit (mfALU). It picks one ready multiply reservation station per cycle by round-robin and drives the multiplier operands with EN. It tracks in-flight ops and their tags in a shadow pipeline, and buffers finished results in a FIFO that drains to the CDB under a valid/ack handshake. Issue is credit-limited, so no result is ever dropped while the CDB stalls.

Parameters:
NUM_RS, 3, number of multiply reservation stations (requesters), 2..8
LAT, 6, multiplier latency in clock edges from the EN edge to a valid result register
DEPTH, 4, result FIFO entries; also the maximum number of ops in flight plus buffered

Ports:
clk  in  1  clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
rsReady  in  NUM_RS  station i has both operands valid
rsLabel  in  4*NUM_RS  tag of station i, slice [4i+3:4i]
rsData1  in  32*NUM_RS  operand 1 of station i
rsData2  in  32*NUM_RS  operand 2 of station i
rsGrant  out  NUM_RS  one-hot grant; the station frees its entry on this edge
aluEN  out  1  issue strobe to the multiplier EN
aluData1  out  32  granted operand 1
aluData2  out  32  granted operand 2
aluResult  in  32  multiplier result register
cdbValid  out  1  FIFO head valid
cdbData  out  32  FIFO head result
cdbLabel  out  4  FIFO head tag
cdbAck  in  1  CDB accepts the head this cycle
busy  out  1  any op in flight or buffered

Behaviour:
- Reset (async, nRST low): ptr=0, shadow valid bits=0, shadow labels=0, FIFO empty, count=0.
  - Outputs during and after reset: cdbValid=0, cdbData=0, cdbLabel=0, busy=0.
  - rsGrant and aluEN are forced 0 while nRST is low.
- Credit: count = in-flight ops + FIFO entries. canIssue = (count < DEPTH). A pop in the same cycle does not free a credit until the next cycle.
- Arbitration (combinational):
  - Grant the first i with rsReady[i], searching ptr, ptr+1, … mod NUM_RS.
  - Grant only when canIssue; no grant when no station is ready.
  - aluEN = |rsGrant.
  - aluData1/aluData2 = the granted slices; 0 when there is no grant.
- ptr: on a grant edge, ptr <= (granted index + 1) mod NUM_RS. Otherwise ptr holds.
- Shadow pipeline (the mfALU labelOut is not pipelined and is ignored):
  - Every edge: pv <= {pv[LAT-2:0], aluEN} and lab[k] <= lab[k-1], with lab[0] <= granted tag.
  - Op issued at edge T has pv[LAT-1]=1 in the cycle after edge T+LAT-1. In that cycle aluResult is its product.
- Push: when pv[LAT-1]=1, at the next edge push {aluResult, lab[LAT-1]} into the FIFO. By construction the push can never find the FIFO full.
- Pop: when cdbAck && cdbValid, advance the head at the edge. cdbAck while empty is ignored.
- Simultaneous push and pop: both happen; occupancy is unchanged.
- count update per edge: +aluEN − (pop); pushes are a transfer between pipeline and FIFO and do not change count.
- cdbData/cdbLabel show the head entry; both are 0 when the FIFO is empty. FIFO pointers wrap mod DEPTH.
- busy = (count != 0).
- Arithmetic: the result is the low 32 bits of the unsigned product. Wrap-around is not flagged.
- Ordering: results reach the CDB strictly in issue order.

Test Plan:
1. Single op: station 1 ready, label 5, operands 3 and 7 → rsGrant=3'b010 in cycle 0 and aluData 3/7. cdbValid rises after edge 6 with cdbData=21, cdbLabel=5. With cdbAck=1, cdbValid drops the next cycle and busy=0.
2. Round-robin plus credits: all three stations ready continuously, ptr=0, no ack → grants 0,1,2,0 on four consecutive cycles, then rsGrant=0 (count=4). The first ack pop re-enables a grant to station 1 on the following cycle.
3. Back-to-back ops: issue (2,3), (4,5), (6,7), (0xFFFFFFFF,2) on consecutive cycles with labels 1..4 and cdbAck held 1 → CDB outputs 6, 20, 42, 0xFFFFFFFE on consecutive cycles with labels 1,2,3,4.
4. Backpressure: cdbAck=0 for 20 cycles with 4 ops issued → FIFO holds 4, cdbValid stays 1 and the head is stable. Releasing ack drains the entries in order with none lost or duplicated.
5. Reset mid-operation: assert nRST low while 2 ops are in flight and 1 is buffered → outputs clear immediately. After release, cdbValid stays 0 for 10 cycles and busy=0.
6. Stray ack and edge case: cdbAck=1 with the FIFO empty → no state change. A push and a pop in the same cycle with 1 entry buffered → occupancy stays 1 and the order is preserved.
